// File: rtl/sine_wg_pkg.sv
// Shared types and width helpers for the sine wave generator sweep controller.
package sine_wg_pkg;

    typedef enum logic [1:0] {ModeStop, ModeOneShot, ModeLoop, ModePingPong} sweep_mode_t;
    typedef enum logic [1:0] {StIdle, StRunUp, StRunDown, StHold} sweep_state_t;

    function automatic int unsigned freq_width(input int unsigned sample_frequency);
        return $clog2(sample_frequency / 2);
    endfunction

    // A single channel still needs a 1-bit channel field.
    function automatic int unsigned ch_width(input int unsigned nr_channels);
        return (nr_channels > 1) ? $clog2(nr_channels) : 1;
    endfunction

endpackage

// File: rtl/sine_wg_sweep_step.sv
// One sweep step for one channel: moves freq toward stop and resolves the end-of-sweep action.
module sine_wg_sweep_step
    import sine_wg_pkg::*;
#(
    parameter int unsigned FW = 15
) (
    input  logic [FW-1:0] freq_i,
    input  logic [FW-1:0] start_i,
    input  logic [FW-1:0] stop_i,
    input  logic [FW-1:0] step_i,
    input  logic [1:0]    state_i,
    input  logic [1:0]    mode_i,
    output logic [FW-1:0] freq_o,
    output logic [1:0]    state_o,
    output logic          done_o
);

    sweep_state_t st;
    sweep_mode_t  md;
    logic [FW:0]   up_sum;
    logic [FW:0]   dn_lim;
    logic [FW-1:0] moved;

    assign st = sweep_state_t'(state_i);
    assign md = sweep_mode_t'(mode_i);

    always_comb begin
        up_sum = {1'b0, freq_i} + {1'b0, step_i};
        dn_lim = {1'b0, stop_i} + {1'b0, step_i};
        if (st == StRunUp) begin
            moved = (up_sum >= {1'b0, stop_i}) ? stop_i : up_sum[FW-1:0];
        end else begin
            moved = ({1'b0, freq_i} <= dn_lim) ? stop_i : freq_i - step_i;
        end

        freq_o  = freq_i;
        state_o = state_i;
        done_o  = 1'b0;
        if (st == StRunUp || st == StRunDown) begin
            // Loop wraps one step after reaching stop, so stop dwells like every other point.
            if (md == ModeLoop && freq_i == stop_i) begin
                freq_o = start_i;
            end else begin
                freq_o = moved;
                if (moved == stop_i) begin
                    if (md == ModeOneShot) begin
                        state_o = StHold;
                        done_o  = 1'b1;
                    end else if (md == ModePingPong) begin
                        state_o = (st == StRunUp) ? StRunDown : StRunUp;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sine_wg_sweep_ctrl.sv
// Per-channel frequency scheduler: one pending config slot, per-channel linear sweeps
// that advance only on that channel's sample handoff.
module sine_wg_sweep_ctrl
    import sine_wg_pkg::*;
#(
    parameter int unsigned NR_CHANNELS      = 2,
    parameter int unsigned SAMPLE_FREQUENCY = 48000,
    parameter int unsigned DWELL_WIDTH      = 16,
    localparam int unsigned FW = freq_width(SAMPLE_FREQUENCY),
    localparam int unsigned CW = ch_width(NR_CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CW-1:0]          s_cfg_ch,
    input  logic [FW-1:0]          s_cfg_start,
    input  logic [FW-1:0]          s_cfg_stop,
    input  logic [FW-1:0]          s_cfg_step,
    input  logic [DWELL_WIDTH-1:0] s_cfg_dwell,
    input  logic [1:0]             s_cfg_mode,
    input  logic                   s_cfg_dv,
    output logic                   s_cfg_dr,
    output logic [FW-1:0]          sg_frequency,
    input  logic [CW-1:0]          sg_freq_ch,
    input  logic [6:0]             sg_freq_step,
    input  logic [CW-1:0]          m_sg_ch,
    input  logic                   m_sg_dv,
    input  logic                   m_sg_dr,
    output logic [NR_CHANNELS-1:0] sweep_active,
    output logic                   sweep_done,
    output logic [CW-1:0]          sweep_done_ch
);

    localparam logic [FW-1:0] FMAX = FW'(SAMPLE_FREQUENCY / 2 - 1);

    function automatic logic [FW-1:0] clamp_f(input logic [FW-1:0] f);
        return (f > FMAX) ? FMAX : f;
    endfunction

    sweep_state_t           state_q [NR_CHANNELS];
    sweep_mode_t            mode_q  [NR_CHANNELS];
    logic [FW-1:0]          freq_q  [NR_CHANNELS];
    logic [FW-1:0]          start_q [NR_CHANNELS];
    logic [FW-1:0]          stop_q  [NR_CHANNELS];
    logic [FW-1:0]          step_q  [NR_CHANNELS];
    logic [DWELL_WIDTH-1:0] dwell_q [NR_CHANNELS];
    logic [DWELL_WIDTH-1:0] cnt_q   [NR_CHANNELS];

    logic                   pend_q;
    logic [CW-1:0]          pend_ch_q;
    logic [FW-1:0]          pend_start_q;
    logic [FW-1:0]          pend_stop_q;
    logic [FW-1:0]          pend_step_q;
    logic [DWELL_WIDTH-1:0] pend_dwell_q;
    sweep_mode_t            pend_mode_q;

    logic          done_q;
    logic [CW-1:0] done_ch_q;

    logic          hs;
    logic          h_ok;
    logic          f_ok;
    logic          apply;
    logic          run_h;
    logic [FW-1:0] step_eff;
    logic [FW-1:0] nxt_freq;
    logic [1:0]    nxt_state;
    logic          nxt_done;

    assign hs       = m_sg_dv & m_sg_dr;
    assign h_ok     = 32'(m_sg_ch) < NR_CHANNELS;
    assign f_ok     = 32'(sg_freq_ch) < NR_CHANNELS;
    assign apply    = hs & h_ok & pend_q & (m_sg_ch == pend_ch_q);
    assign run_h    = (state_q[m_sg_ch] == StRunUp) | (state_q[m_sg_ch] == StRunDown);
    assign step_eff = (s_cfg_step == '0) ? FW'(sg_freq_step) : s_cfg_step;

    assign s_cfg_dr      = ~pend_q;
    assign sg_frequency  = f_ok ? freq_q[sg_freq_ch] : '0;
    assign sweep_done    = done_q;
    assign sweep_done_ch = done_ch_q;

    always_comb begin
        sweep_active = '0;
        for (int c = 0; c < int'(NR_CHANNELS); c++) begin
            sweep_active[c] = (state_q[c] == StRunUp) | (state_q[c] == StRunDown);
        end
    end

    sine_wg_sweep_step #(
        .FW (FW)
    ) u_step (
        .freq_i  (freq_q[m_sg_ch]),
        .start_i (start_q[m_sg_ch]),
        .stop_i  (stop_q[m_sg_ch]),
        .step_i  (step_q[m_sg_ch]),
        .state_i (state_q[m_sg_ch]),
        .mode_i  (mode_q[m_sg_ch]),
        .freq_o  (nxt_freq),
        .state_o (nxt_state),
        .done_o  (nxt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NR_CHANNELS); c++) begin
                state_q[c] <= StIdle;
                mode_q[c]  <= ModeStop;
                freq_q[c]  <= '0;
                start_q[c] <= '0;
                stop_q[c]  <= '0;
                step_q[c]  <= '0;
                dwell_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
            pend_q       <= 1'b0;
            pend_ch_q    <= '0;
            pend_start_q <= '0;
            pend_stop_q  <= '0;
            pend_step_q  <= '0;
            pend_dwell_q <= '0;
            pend_mode_q  <= ModeStop;
            done_q       <= 1'b0;
            done_ch_q    <= '0;
        end else begin
            done_q <= 1'b0;

            if (s_cfg_dv && s_cfg_dr) begin
                pend_q       <= 1'b1;
                pend_ch_q    <= s_cfg_ch;
                pend_start_q <= clamp_f(s_cfg_start);
                pend_stop_q  <= clamp_f(s_cfg_stop);
                pend_step_q  <= step_eff;
                pend_dwell_q <= s_cfg_dwell;
                pend_mode_q  <= sweep_mode_t'(s_cfg_mode);
            end

            if (apply) begin
                // A start of 0 keeps the channel muted, same as STOP.
                pend_q                <= 1'b0;
                mode_q[pend_ch_q]     <= pend_mode_q;
                start_q[pend_ch_q]    <= pend_start_q;
                stop_q[pend_ch_q]     <= pend_stop_q;
                step_q[pend_ch_q]     <= pend_step_q;
                dwell_q[pend_ch_q]    <= pend_dwell_q;
                cnt_q[pend_ch_q]      <= '0;
                if (pend_mode_q == ModeStop || pend_start_q == '0) begin
                    state_q[pend_ch_q] <= StIdle;
                    freq_q[pend_ch_q]  <= '0;
                end else begin
                    state_q[pend_ch_q] <= (pend_start_q <= pend_stop_q) ? StRunUp : StRunDown;
                    freq_q[pend_ch_q]  <= pend_start_q;
                end
            end else if (hs && h_ok && run_h) begin
                if (cnt_q[m_sg_ch] != dwell_q[m_sg_ch]) begin
                    cnt_q[m_sg_ch] <= cnt_q[m_sg_ch] + 1'b1;
                end else begin
                    cnt_q[m_sg_ch]   <= '0;
                    freq_q[m_sg_ch]  <= nxt_freq;
                    state_q[m_sg_ch] <= sweep_state_t'(nxt_state);
                    if (mode_q[m_sg_ch] == ModePingPong && nxt_state != state_q[m_sg_ch]) begin
                        start_q[m_sg_ch] <= stop_q[m_sg_ch];
                        stop_q[m_sg_ch]  <= start_q[m_sg_ch];
                    end
                    done_q    <= nxt_done;
                    done_ch_q <= m_sg_ch;
                end
            end
        end
    end

endmodule
